// File: rtl/ccr_pkg.sv
// rtl/ccr_pkg.sv - shared flag indices, branch selects and shadow depth default
package ccr_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam int SHADOW_DEPTH_DEF = 2;
    localparam int CNT_W            = 2;

    typedef logic [3:0] flags_t;

    typedef enum logic [1:0] {
        BR_Z = 2'b00,
        BR_N = 2'b01,
        BR_C = 2'b10,
        BR_V = 2'b11
    } br_sel_e;

endpackage

// File: rtl/ccr_shadow_stack.sv
// rtl/ccr_shadow_stack.sv - LIFO of flag snapshots with occupancy counter
module ccr_shadow_stack
    import ccr_pkg::*;
#(
    parameter int DEPTH = SHADOW_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  flags_t           din,
    output flags_t           dout,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flags_t        mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = cnt[IW-1:0];
    assign rd_idx = wr_idx - IW'(1);
    assign full   = (cnt == CNT_W'(DEPTH));
    assign empty  = (cnt == '0);
    assign dout   = mem[rd_idx];

    // Snapshot storage is deliberately left out of reset; only cnt decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ccr_unit.sv
// rtl/ccr_unit.sv - condition code register with interrupt shadow stack and branch resolve
module ccr_unit
    import ccr_pkg::*;
#(
    parameter int SHADOW_DEPTH = SHADOW_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_c,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic [3:0] flag_we,
    input  logic       stall,
    input  logic       int_save,
    input  logic       rti_restore,
    input  logic       br_en,
    input  logic [1:0] br_sel,
    output logic       c,
    output logic       z,
    output logic       n,
    output logic       v,
    output logic       br_taken,
    output logic [1:0] shadow_cnt,
    output logic       stack_err
);

    flags_t             flags;
    flags_t             alu_flags;
    flags_t             upd_flags;
    flags_t             stack_dout;
    logic [CNT_W-1:0]   stack_cnt;
    logic               stack_full;
    logic               stack_empty;
    logic               do_push;
    logic               do_pop;
    logic               sel_flag;

    assign alu_flags = {alu_v, alu_n, alu_z, alu_c};
    assign upd_flags = (flags & ~flag_we) | (alu_flags & flag_we);

    // Simultaneous save and restore cancels both stack operations.
    assign do_push = !stall && int_save && !rti_restore && !stack_full;
    assign do_pop  = !stall && rti_restore && !int_save && !stack_empty;

    ccr_shadow_stack #(
        .DEPTH (SHADOW_DEPTH)
    ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .din   (flags),
        .dout  (stack_dout),
        .cnt   (stack_cnt),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags     <= '0;
            stack_err <= 1'b0;
        end else if (!stall) begin
            if (int_save && rti_restore) begin
                stack_err <= 1'b1;
                flags     <= upd_flags;
            end else if (rti_restore) begin
                if (stack_empty) begin
                    stack_err <= 1'b1;
                end else begin
                    flags <= stack_dout;
                end
            end else begin
                if (int_save && stack_full) begin
                    stack_err <= 1'b1;
                end
                flags <= upd_flags;
            end
        end
    end

    always_comb begin
        sel_flag = 1'b0;
        case (br_sel_e'(br_sel))
            BR_Z: sel_flag = flags[FLAG_Z];
            BR_N: sel_flag = flags[FLAG_N];
            BR_C: sel_flag = flags[FLAG_C];
            BR_V: sel_flag = flags[FLAG_V];
            default: sel_flag = 1'b0;
        endcase
    end

    assign br_taken   = br_en && sel_flag;
    assign c          = flags[FLAG_C];
    assign z          = flags[FLAG_Z];
    assign n          = flags[FLAG_N];
    assign v          = flags[FLAG_V];
    assign shadow_cnt = stack_cnt;

endmodule

// File: tb/tb_ccr_unit.sv
// tb/tb_ccr_unit.sv - directed scoreboard bench for ccr_unit
module tb_ccr_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_c, alu_z, alu_n, alu_v;
    logic [3:0] flag_we;
    logic       stall, int_save, rti_restore, br_en;
    logic [1:0] br_sel;
    logic       c, z, n, v, br_taken, stack_err;
    logic [1:0] shadow_cnt;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q [$];

    ccr_unit #(.SHADOW_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .alu_v       (alu_v),
        .flag_we     (flag_we),
        .stall       (stall),
        .int_save    (int_save),
        .rti_restore (rti_restore),
        .br_en       (br_en),
        .br_sel      (br_sel),
        .c           (c),
        .z           (z),
        .n           (n),
        .v           (v),
        .br_taken    (br_taken),
        .shadow_cnt  (shadow_cnt),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_out(input string tag);
        logic [6:0] exp_v;
        logic [6:0] obs;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            exp_v = exp_q.pop_front();
            obs   = {v, n, z, c, shadow_cnt, stack_err};
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed vnzc=%b cnt=%0d err=%b expected vnzc=%b cnt=%0d err=%b",
                       tag, obs[6:3], obs[2:1], obs[0], exp_v[6:3], exp_v[2:1], exp_v[0]);
            end
        end
    endtask

    task automatic check_br(input string tag, input logic exp_b);
        checks++;
        assert (br_taken === exp_b) else begin
            errors++;
            $error("FAIL %s observed br_taken=%b expected %b", tag, br_taken, exp_b);
        end
    endtask

    // Drives one cycle of stimulus, queues its expected result, checks after the edge.
    task automatic step(input logic [3:0] we, input logic [3:0] alu, input logic sv,
                        input logic rs, input logic st, input logic [3:0] ef,
                        input logic [1:0] ec, input logic ee, input string tag);
        flag_we = we;
        {alu_v, alu_n, alu_z, alu_c} = alu;
        int_save = sv;
        rti_restore = rs;
        stall = st;
        exp_q.push_back({ef, ec, ee});
        @(posedge clk);
        #1;
        flag_we = 4'b0000;
        int_save = 1'b0;
        rti_restore = 1'b0;
        stall = 1'b0;
        check_out(tag);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {alu_v, alu_n, alu_z, alu_c} = 4'b0000;
        flag_we = 4'b0000;
        stall = 1'b0;
        int_save = 1'b0;
        rti_restore = 1'b0;
        br_en = 1'b1;
        br_sel = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({4'b0000, 2'd0, 1'b0});
        check_out("reset_state");
        check_br("reset_br", 1'b0);
        rst = 1'b0;
        br_en = 1'b0;

        step(4'b1111, 4'b0101, 0, 0, 0, 4'b0101, 2'd0, 0, "load_all");
        br_en = 1'b1;
        br_sel = 2'b01; #1; check_br("br_n", 1'b1);
        br_sel = 2'b00; #1; check_br("br_z", 1'b0);
        br_sel = 2'b10; #1; check_br("br_c", 1'b1);
        br_sel = 2'b11; #1; check_br("br_v", 1'b0);
        br_en = 1'b0;   #1; check_br("br_disabled", 1'b0);

        step(4'b0000, 4'b1010, 0, 0, 0, 4'b0101, 2'd0, 0, "we_zero_hold");
        step(4'b1111, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 0, "set_0001");
        step(4'b0010, 4'b0010, 0, 0, 0, 4'b0011, 2'd0, 0, "partial_we_z");

        step(4'b1111, 4'b1010, 0, 0, 0, 4'b1010, 2'd0, 0, "set_1010");
        step(4'b1111, 4'b0101, 1, 0, 0, 4'b0101, 2'd1, 0, "save_with_we");
        step(4'b1111, 4'b1111, 0, 1, 0, 4'b1010, 2'd0, 0, "restore_wins");

        br_en = 1'b1;
        br_sel = 2'b11;
        stall = 1'b1;
        #1; check_br("br_during_stall", 1'b1);
        step(4'b1111, 4'b0000, 1, 0, 1, 4'b1010, 2'd0, 0, "stall_hold");
        br_en = 1'b0;
        step(4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 2'd1, 0, "save_after_stall");
        step(4'b0000, 4'b0000, 0, 1, 0, 4'b1010, 2'd0, 0, "restore_after_stall");

        step(4'b1111, 4'b0110, 1, 0, 0, 4'b0110, 2'd1, 0, "push1");
        step(4'b1111, 4'b1001, 1, 0, 0, 4'b1001, 2'd2, 0, "push2");
        step(4'b1111, 4'b1100, 1, 0, 0, 4'b1100, 2'd2, 1, "push_full");
        step(4'b0000, 4'b0000, 0, 1, 0, 4'b0110, 2'd1, 1, "pop_second");
        step(4'b0000, 4'b0000, 0, 1, 0, 4'b1010, 2'd0, 1, "pop_first");
        step(4'b1111, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, "err_sticky");

        sync_reset();
        step(4'b1111, 4'b0011, 1, 1, 0, 4'b0011, 2'd0, 1, "save_and_restore");

        sync_reset();
        step(4'b1111, 4'b0110, 0, 0, 0, 4'b0110, 2'd0, 0, "pre_underflow");
        step(4'b1111, 4'b1001, 0, 1, 0, 4'b0110, 2'd0, 1, "pop_empty");

        br_en = 1'b1;
        br_sel = 2'b01;
        int_save = 1'b1;
        #1; check_br("br_before_async_rst", 1'b1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back({4'b0000, 2'd0, 1'b0});
        check_out("async_reset");
        check_br("br_after_async_rst", 1'b0);
        rst = 1'b0;
        int_save = 1'b0;
        br_en = 1'b0;
        step(4'b0000, 4'b1111, 0, 0, 0, 4'b0000, 2'd0, 0, "post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
